dpram_port_arbiter: RTL and testbench
=====================================

# dpram_port_arbiter

Two-client access controller placed in front of the 256x16 dual-port RAM (`DPRAM`). Client 0 is steered to port A and client 1 to port B. Same-address conflicts (at least one side writing) are detected and serialized with a starvation-free round-robin policy. Read data is returned with a registered valid strobe, and a saturating counter records detected conflicts.

## Interface
Parameters:
- AW, 8, address width (RAM depth 2^AW)
- DW, 16, data width
- CW, 16, collision counter width

Ports:
- clk  in  1  single clock, also drives the RAM's clka and clkb
- rst  in  1  reset, synchronous, active-high
- c0_req  in  1  client 0 access request; held until granted
- c0_we  in  1  client 0 write (1) / read (0)
- c0_addr  in  AW  client 0 address
- c0_wdata  in  DW  client 0 write data
- c0_gnt  out  1  client 0 request accepted this cycle (combinational)
- c0_rvalid  out  1  client 0 read data valid
- c0_rdata  out  DW  client 0 read data
- c1_req, c1_we, c1_addr, c1_wdata, c1_gnt, c1_rvalid, c1_rdata: same as the c0_ ports, for client 1
- ena, wea  out  1  RAM port A enable / write enable
- addra  out  AW  RAM port A address
- data_i_a  out  DW  RAM port A write data
- data_o_a  in  DW  RAM port A read data
- enb, web, addrb, data_i_b, data_o_b: same as port A, for port B
- coll_cnt  out  CW  saturating conflict count

## Operation
- Conflict: c0_req & c1_req & (c0_addr == c1_addr) & (c0_we | c1_we). Read-read to the same address is not a conflict; both clients are granted.
- No conflict: each requesting client is granted. Its request drives its port: enX = 1, weX = cX_we, addrX = cX_addr, data_i_X = cX_wdata.
- Conflict: exactly one winner is granted. The loser sees gnt = 0 and its port stays idle: enX = 0, weX = 0.
- The arbitration FSM has 3 states:
  - NORMAL: the winner is the client selected by the prio register. The loser moves the FSM to DEFER0 or DEFER1 (whichever matches the loser), and prio toggles.
  - DEFERx: client x wins any conflict unconditionally. The FSM returns to NORMAL after one cycle, whether or not a conflict occurs.
  - Result: the loser is always granted within one cycle.
- If the deferred client drops its req (a protocol violation), the DEFER state still exits after one cycle. No error is flagged.
- coll_cnt increments by 1 on each cycle a conflict is detected and saturates at 2^CW-1.
- Read return:
  - cX_rvalid is registered: cX_gnt & ~cX_we from the previous cycle.
  - cX_rdata is the RAM's data_o_X passed through.
  - cX_rdata is valid only while cX_rvalid = 1.
- Writes produce no response beyond gnt.

## Timing
- Grant is same-cycle. The RAM samples the command on the next rising clk edge.
- Read latency is 1 cycle: rvalid is high in the cycle after gnt, and the RAM's registered output is valid in that cycle.
- Back-to-back: a client may hold req high across consecutive cycles and receive a grant every cycle unless it loses a conflict.
- While rst = 1:
  - all gnt = 0, ena = enb = 0, wea = web = 0;
  - addra, addrb, data_i_a, data_i_b = 0.
- Values established by reset:
  - c0_rvalid = c1_rvalid = 0
  - coll_cnt = 0
  - FSM = NORMAL
  - prio = client 0
- Reset mid-operation: a read granted in the cycle when rst rises produces no rvalid.

## Structure
- Shared package `dpram_pkg`:
  - AW, DW, CW defaults;
  - arbitration state encoding: NORMAL = 2'd0, DEFER0 = 2'd1, DEFER1 = 2'd2.
- Sub-module `dpram_port_mux`, instantiated once per port: combinational steering of one client onto one RAM port, with a grant-qualified enable.
- The top level holds the FSM, the prio register, the rvalid registers and coll_cnt.

## Test plan
- Reset, then independent writes: c0 writes 9 to address 0 and c1 writes 10 to address 1 in the same cycle. Required: both gnt = 1 in that cycle, ena = enb = wea = web = 1, coll_cnt = 0. Then c0 reads address 1 and c1 reads address 0: 1 cycle later c0_rdata = 10 and c1_rdata = 9, with both rvalid = 1.
- Write-write conflict: c0 writes 7 and c1 writes 8, both to address 2. Required sequence:
  - cycle 0: c0 granted, c1 stalled, coll_cnt = 1;
  - cycle 1: c1 granted, FSM DEFER1 → NORMAL;
  - a later read of address 2 returns 8.
- Repeated conflict fairness: both clients hold write requests to address 3 for 6 cycles. Required: grants alternate c0, c1, c0, c1…; neither client waits more than 1 cycle; coll_cnt = 3.
- Read-read to the same address: both clients read address 4 (preloaded with 6). Required: both gnt = 1 in the same cycle, both rdata = 6, coll_cnt unchanged.
- Read-write conflict: c0 reads address 5 while c1 writes 5 to address 5, with prio = c1. Required: c1 granted first; c0 granted the next cycle and its rdata = 5 (new data).
- Reset mid-operation plus saturation:
  - Assert rst in the same cycle a c0 read is granted. Required: no c0_rvalid afterwards, coll_cnt = 0.
  - Separately, with CW = 2, force 5 conflicts. Required: coll_cnt stops at 3.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared definitions for the two-client dual-port RAM access controller.
// Holds default widths, the arbitration state encoding and the winner-select helper.
package dpram_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 16;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_DEFER0 = 2'd1,
        ST_DEFER1 = 2'd2
    } arb_state_t;

    // Returns 1 when client 1 takes a conflicting cycle; a deferred client always wins.
    function automatic logic c1_wins(input arb_state_t st, input logic prio);
        logic w;
        case (st)
            ST_DEFER0: w = 1'b0;
            ST_DEFER1: w = 1'b1;
            default:   w = prio;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dpram_port_mux.sv
// Steers one client onto one RAM port; the port is idle (all zero) unless granted.
module dpram_port_mux
    import dpram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          i_gnt,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic          o_en,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_wdata
);

    always_comb begin
        o_en    = i_gnt;
        o_we    = i_gnt & i_we;
        o_addr  = i_gnt ? i_addr  : '0;
        o_wdata = i_gnt ? i_wdata : '0;
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Two-client front end for a dual-port RAM: same-address conflicts are serialized
// round-robin, read valids are registered and conflicts are counted with saturation.
module dpram_port_arbiter
    import dpram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c0_req,
    input  logic          c0_we,
    input  logic [AW-1:0] c0_addr,
    input  logic [DW-1:0] c0_wdata,
    output logic          c0_gnt,
    output logic          c0_rvalid,
    output logic [DW-1:0] c0_rdata,
    input  logic          c1_req,
    input  logic          c1_we,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_gnt,
    output logic          c1_rvalid,
    output logic [DW-1:0] c1_rdata,
    output logic          ena,
    output logic          wea,
    output logic [AW-1:0] addra,
    output logic [DW-1:0] data_i_a,
    input  logic [DW-1:0] data_o_a,
    output logic          enb,
    output logic          web,
    output logic [AW-1:0] addrb,
    output logic [DW-1:0] data_i_b,
    input  logic [DW-1:0] data_o_b,
    output logic [CW-1:0] coll_cnt
);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic          r_prio;
    logic          w_prio_nxt;
    logic          r_c0_vld_p1;
    logic          r_c1_vld_p1;
    logic [CW-1:0] r_coll_cnt;

    logic          w_c0_act;
    logic          w_c1_act;
    logic          w_conflict;
    logic          w_c1_wins;
    logic          w_c0_gnt;
    logic          w_c1_gnt;

    // Requests are masked during reset so nothing reaches the RAM.
    assign w_c0_act   = c0_req & ~rst;
    assign w_c1_act   = c1_req & ~rst;
    assign w_conflict = w_c0_act & w_c1_act & (c0_addr == c1_addr) & (c0_we | c1_we);
    assign w_c1_wins  = c1_wins(r_state, r_prio);

    assign w_c0_gnt = w_c0_act & (~w_conflict | ~w_c1_wins);
    assign w_c1_gnt = w_c1_act & (~w_conflict |  w_c1_wins);

    assign c0_gnt = w_c0_gnt;
    assign c1_gnt = w_c1_gnt;

    dpram_port_mux #(.AW(AW), .DW(DW)) u_mux_a (
        .i_gnt   (w_c0_gnt),
        .i_we    (c0_we),
        .i_addr  (c0_addr),
        .i_wdata (c0_wdata),
        .o_en    (ena),
        .o_we    (wea),
        .o_addr  (addra),
        .o_wdata (data_i_a)
    );

    dpram_port_mux #(.AW(AW), .DW(DW)) u_mux_b (
        .i_gnt   (w_c1_gnt),
        .i_we    (c1_we),
        .i_addr  (c1_addr),
        .i_wdata (c1_wdata),
        .o_en    (enb),
        .o_we    (web),
        .o_addr  (addrb),
        .o_wdata (data_i_b)
    );

    // A NORMAL-state loss defers the loser for exactly one cycle and hands prio over.
    always_comb begin
        w_state_nxt = ST_NORMAL;
        w_prio_nxt  = r_prio;
        if (r_state == ST_NORMAL && w_conflict) begin
            w_state_nxt = w_c1_wins ? ST_DEFER0 : ST_DEFER1;
            w_prio_nxt  = ~r_prio;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_NORMAL;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    // Stage p1: read valid aligned with the RAM's registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c0_vld_p1 <= 1'b0;
            r_c1_vld_p1 <= 1'b0;
        end else begin
            r_c0_vld_p1 <= w_c0_gnt & ~c0_we;
            r_c1_vld_p1 <= w_c1_gnt & ~c1_we;
        end
    end

    assign c0_rvalid = r_c0_vld_p1;
    assign c1_rvalid = r_c1_vld_p1;
    assign c0_rdata  = data_o_a;
    assign c1_rdata  = data_o_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_coll_cnt <= '0;
        end else if (w_conflict && (r_coll_cnt != {CW{1'b1}})) begin
            r_coll_cnt <= r_coll_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign coll_cnt = r_coll_cnt;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_dpram_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          c0_req, c0_we, c1_req, c1_we;
    logic [AW-1:0] c0_addr, c1_addr;
    logic [DW-1:0] c0_wdata, c1_wdata;
    logic          c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic          ena, wea, enb, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] data_i_a, data_i_b;
    logic [DW-1:0] data_o_a, data_o_b;
    logic [CW-1:0] coll_cnt;

    // Second instance with a 2-bit counter for saturation.
    logic          s_c0_gnt, s_c0_rvalid, s_c1_gnt, s_c1_rvalid;
    logic [DW-1:0] s_c0_rdata, s_c1_rdata;
    logic          s_ena, s_wea, s_enb, s_web;
    logic [AW-1:0] s_addra, s_addrb;
    logic [DW-1:0] s_data_i_a, s_data_i_b;
    logic [DW-1:0] s_zero = '0;
    logic [1:0]    s_coll_cnt;

    int n_chk = 0;
    int n_err = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    dpram_port_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .ena(ena), .wea(wea), .addra(addra), .data_i_a(data_i_a), .data_o_a(data_o_a),
        .enb(enb), .web(web), .addrb(addrb), .data_i_b(data_i_b), .data_o_b(data_o_b),
        .coll_cnt(coll_cnt)
    );

    dpram_port_arbiter #(.AW(AW), .DW(DW), .CW(2)) dut_sat (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(s_c0_gnt), .c0_rvalid(s_c0_rvalid), .c0_rdata(s_c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(s_c1_gnt), .c1_rvalid(s_c1_rvalid), .c1_rdata(s_c1_rdata),
        .ena(s_ena), .wea(s_wea), .addra(s_addra), .data_i_a(s_data_i_a), .data_o_a(s_zero),
        .enb(s_enb), .web(s_web), .addrb(s_addrb), .data_i_b(s_data_i_b), .data_o_b(s_zero),
        .coll_cnt(s_coll_cnt)
    );

    // Behavioural RAM: registered read output, writes leave the output unchanged.
    always @(posedge clk) begin
        if (ena) begin
            if (wea) mem[addra] <= data_i_a;
            else     data_o_a   <= mem[addra];
        end
        if (enb) begin
            if (web) mem[addrb] <= data_i_b;
            else     data_o_b   <= mem[addrb];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        c0_req = r0; c0_we = w0; c0_addr = a0; c0_wdata = d0;
        c1_req = r1; c1_we = w1; c1_addr = a1; c1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, 8'd0, 16'd0, 0, 0, 8'd0, 16'd0);
    endtask

    // Scoreboard monitor: every read valid must match the next queued value.
    always @(negedge clk) begin
        if (!rst) begin
            if (c0_rvalid) begin
                if (q0.size() == 0) check("c0_spurious_rvalid", 1, 0);
                else check("c0_rdata", c0_rdata, q0.pop_front());
            end
            if (c1_rvalid) begin
                if (q1.size() == 0) check("c1_spurious_rvalid", 1, 0);
                else check("c1_rdata", c1_rdata, q1.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_win [3];
        exp_win = '{1'b0, 1'b1, 1'b0};
        rst = 1'b1;
        idle();
        tick();
        tick();

        // Reset: requests present but everything held off.
        drive(1, 1, 8'd0, 16'd9, 1, 1, 8'd1, 16'd10);
        #1;
        check("rst_c0_gnt", c0_gnt, 0);
        check("rst_c1_gnt", c1_gnt, 0);
        check("rst_en", {ena, enb, wea, web}, 0);
        check("rst_addr", {addra, addrb}, 0);
        check("rst_wdata", {data_i_a, data_i_b}, 0);
        tick();
        check("rst_rvalid", {c0_rvalid, c1_rvalid}, 0);
        check("rst_coll", coll_cnt, 0);

        // Independent writes.
        rst = 1'b0;
        #1;
        check("t1_gnt", {c0_gnt, c1_gnt}, 2'b11);
        check("t1_en_we", {ena, enb, wea, web}, 4'b1111);
        check("t1_addrb", addrb, 1);
        tick();
        check("t1_coll", coll_cnt, 0);
        drive(1, 0, 8'd1, 16'd0, 1, 0, 8'd0, 16'd0);
        #1;
        check("t1_rd_gnt", {c0_gnt, c1_gnt}, 2'b11);
        q0.push_back(16'd10);
        q1.push_back(16'd9);
        tick();
        idle();
        check("t1_rvalid", {c0_rvalid, c1_rvalid}, 2'b11);

        // Write-write conflict on address 2.
        drive(1, 1, 8'd2, 16'd7, 1, 1, 8'd2, 16'd8);
        #1;
        check("t2_c0_gnt", c0_gnt, 1);
        check("t2_c1_gnt", c1_gnt, 0);
        check("t2_b_idle", {enb, web}, 0);
        tick();
        check("t2_coll", coll_cnt, 1);
        drive(0, 0, 8'd0, 16'd0, 1, 1, 8'd2, 16'd8);
        #1;
        check("t2_c1_gnt_defer", c1_gnt, 1);
        tick();
        drive(1, 0, 8'd2, 16'd0, 0, 0, 8'd0, 16'd0);
        #1;
        check("t2_rd_gnt", c0_gnt, 1);
        q0.push_back(16'd8);
        tick();
        idle();
        tick();

        // Fairness: three conflicting write pairs on address 3 after a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int p = 0; p < 3; p++) begin
            drive(1, 1, 8'd3, 16'h30 + 16'(p), 1, 1, 8'd3, 16'h40 + 16'(p));
            #1;
            check("t3_win_c0", c0_gnt, exp_win[p] == 1'b0);
            check("t3_win_c1", c1_gnt, exp_win[p] == 1'b1);
            tick();
            if (exp_win[p]) drive(1, 1, 8'd3, 16'h30 + 16'(p), 0, 0, 8'd0, 16'd0);
            else            drive(0, 0, 8'd0, 16'd0, 1, 1, 8'd3, 16'h40 + 16'(p));
            #1;
            check("t3_loser_gnt", exp_win[p] ? c0_gnt : c1_gnt, 1);
            tick();
        end
        check("t3_coll", coll_cnt, 3);
        drive(0, 0, 8'd0, 16'd0, 1, 0, 8'd3, 16'd0);
        #1;
        check("t3_rd_gnt", c1_gnt, 1);
        q1.push_back(16'h42);
        tick();

        // Read-read to the same address.
        drive(1, 1, 8'd4, 16'd6, 0, 0, 8'd0, 16'd0);
        tick();
        drive(1, 0, 8'd4, 16'd0, 1, 0, 8'd4, 16'd0);
        #1;
        check("t4_gnt", {c0_gnt, c1_gnt}, 2'b11);
        q0.push_back(16'd6);
        q1.push_back(16'd6);
        tick();
        idle();
        check("t4_coll", coll_cnt, 3);

        // Read-write conflict, prio currently on client 1.
        drive(1, 0, 8'd5, 16'd0, 1, 1, 8'd5, 16'd5);
        #1;
        check("t5_c0_gnt", c0_gnt, 0);
        check("t5_c1_gnt", c1_gnt, 1);
        tick();
        check("t5_coll", coll_cnt, 4);
        drive(1, 0, 8'd5, 16'd0, 0, 0, 8'd0, 16'd0);
        #1;
        check("t5_c0_gnt_defer", c0_gnt, 1);
        q0.push_back(16'd5);
        tick();
        idle();
        tick();

        // Reset arrives with a c0 read.
        drive(1, 0, 8'd5, 16'd0, 0, 0, 8'd0, 16'd0);
        rst = 1'b1;
        #1;
        check("t6_gnt", c0_gnt, 0);
        check("t6_ena", ena, 0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("t6_rvalid", c0_rvalid, 0);
        check("t6_coll", coll_cnt, 0);

        // Saturation: five conflicting cycles.
        drive(1, 1, 8'd7, 16'd1, 1, 1, 8'd7, 16'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) check("sat_cnt_2", s_coll_cnt, 2);
        end
        idle();
        check("sat_cnt_3", s_coll_cnt, 3);
        check("wide_cnt_5", coll_cnt, 5);
        tick();
        tick();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
